// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised modulo-MODULUS up/down counter with
// enable prescaler, registered terminal-count pulse and sticky overflow.
//
// Optional feature macro: PCNT_SAT_EN
//   defined   -> mode=1 saturates at the boundary, mode=0 wraps
//   undefined -> mode is ignored, the counter always wraps
//
// Parameters:
//   WIDTH    counter width, 2..32
//   MODULUS  count range 0..MODULUS-1, 2..2^WIDTH
//   PRESCALE enabled cycles per count tick, 1..256
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   load       in   load data_in (clamped to MODULUS-1)
//   data_in    in   load value
//   enable     in   advances the prescaler
//   up_down    in   1 = up, 0 = down
//   mode       in   0 = wrap, 1 = saturate (PCNT_SAT_EN only)
//   clr_flag   in   clears sticky_ovf
//   count      out  registered count
//   tc         out  registered one-cycle boundary pulse
//   sticky_ovf out  set on a boundary tick, held until cleared

module param_updown_counter #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enable,
    input  logic             up_down,
    input  logic             mode,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             sticky_ovf
);

    localparam int unsigned PW =
        (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Top count value; comparing against it avoids a
    // WIDTH+1 bit constant when MODULUS == 2^WIDTH.
    localparam logic [WIDTH-1:0] MAX_CNT =
        WIDTH'(MODULUS - 1);

    localparam logic [PW-1:0] PRE_MAX =
        PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [PW-1:0]    pre_q;
    logic [PW-1:0]    pre_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             tick;
    logic             boundary;
    logic             sat;

`ifdef PCNT_SAT_EN
    assign sat = mode;
`else
    // Wrap only; mode is kept in the port list for
    // drop-in compatibility but has no function here.
    logic mode_unused;
    assign mode_unused = mode;
    assign sat         = 1'b0;
`endif

    // With PRESCALE == 1, PRE_MAX is 0 and pre never
    // leaves 0, so every enabled cycle is a tick.
    assign tick = enable && (pre_q == PRE_MAX);

    assign boundary = up_down ? (count_q == MAX_CNT)
                              : (count_q == '0);

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~clr_flag;

        if (load) begin
            // Out-of-range load values clamp to the top.
            count_d = (data_in > MAX_CNT) ? MAX_CNT
                                          : data_in;
            pre_d   = '0;
        end else begin
            if (enable) begin
                pre_d = tick ? '0 : pre_q + 1'b1;
            end
            if (tick) begin
                if (boundary) begin
                    // Set beats a same-cycle clear.
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    if (!sat) begin
                        count_d = up_down ? '0 : MAX_CNT;
                    end
                end else if (up_down) begin
                    count_d = count_q + 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count      = count_q;
    assign tc         = tc_q;
    assign sticky_ovf = ovf_q;

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised synchronous modulo-N up/down counter. It is the next-generation replacement for the team's fixed-width loadable counter and adds a configurable width and modulus, an enable prescaler, a registered terminal-count pulse, a sticky overflow flag and an optional saturate mode. It sits as a leaf timing/event block and is driven by the count environment's write BFM. The count environment's monitors and scoreboard observe it.

## Interface
- WIDTH, 8, counter width in bits; legal 2..32.
- MODULUS, 256, count range 0..MODULUS-1; legal 2..2^WIDTH.
- PRESCALE, 1, enabled cycles per count tick; legal 1..256.

- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  load data_in into count this edge.
- data_in  in  WIDTH  load value.
- enable  in  1  advances the prescaler.
- up_down  in  1  1 = count up, 0 = count down; sampled on tick cycles.
- mode  in  1  0 = wrap, 1 = saturate; effective only with PCNT_SAT_EN.
- clr_flag  in  1  clears sticky_ovf.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle wide.
- sticky_ovf  out  1  set on a boundary tick, held until cleared.

## Operation
- Priority, highest first: reset, then load, then tick.
- Prescaler pre, range 0..PRESCALE-1:
  - Advances only on cycles with enable=1.
  - tick = enable & (pre==PRESCALE-1). pre wraps to 0 on tick.
  - pre holds while enable=0.
  - With PRESCALE=1, every enabled cycle is a tick.
- Load:
  - count <= data_in when data_in < MODULUS; otherwise count <= MODULUS-1 (clamped).
  - pre <= 0.
  - tc stays 0 and sticky_ovf is unchanged.
  - A tick on the same cycle is discarded.
- Tick, up:
  - count < MODULUS-1: count+1.
  - count == MODULUS-1 (boundary): wrap to 0, or hold if saturating.
- Tick, down:
  - count > 0: count-1.
  - count == 0 (boundary): wrap to MODULUS-1, or hold if saturating.
- Boundary tick, in either mode: tc=1 on the next cycle and sticky_ovf set. This repeats on every boundary tick while saturated.
- sticky_ovf:
  - Cleared by clr_flag=1.
  - If a set and clr_flag occur on the same cycle, the set wins.
- Arithmetic is modulo-MODULUS, not 2^WIDTH. count never exceeds MODULUS-1.

## Timing
- Reset values: count=0, tc=0, sticky_ovf=0, pre=0. Reset asserted mid-count takes effect on the next edge and discards any load or tick in that cycle.
- Latency:
  - load or tick: count updated one edge later.
  - tc and sticky_ovf: asserted on the same edge as the boundary count update.
- tc is high for exactly one cycle per boundary tick. Back-to-back boundary ticks (saturate, PRESCALE=1) hold tc high continuously.
- No combinational path from any input to any output.
- A change of up_down or mode between ticks has no effect until the next tick.

## Configuration
- PCNT_SAT_EN defined:
  - mode=1 selects saturate (hold at boundary).
  - mode=0 selects wrap.
- PCNT_SAT_EN undefined:
  - The mode port stays in the port list but is ignored.
  - The counter always wraps and no saturate logic is synthesised.

## Test plan
- Wrap up: WIDTH=4, MODULUS=10, PRESCALE=1; reset, then enable=1, up_down=1 for 12 cycles -> count 1..9,0,1,2; tc=1 only in the cycle count=0; sticky_ovf=1 afterwards.
- Load priority and clamp: load=1, data_in=7, enable=1 -> count=7 next cycle with no increment; load data_in=13 -> count=9; tc stays 0 in both cases.
- Wrap down: load 2, then up_down=0 with 3 ticks -> 1,0,9; tc pulses with count=9; clr_flag=1 -> sticky_ovf=0 next cycle.
- Prescale: PRESCALE=4 from count=0; enable=1 for 6 cycles, 0 for 2, 1 for 2 -> count=1 after the 4th enabled cycle and 2 after the 8th enabled cycle; count held during the enable=0 cycles.
- Saturate (PCNT_SAT_EN, mode=1): load 8, up with 3 ticks -> 9,9,9; tc=0 on the 8→9 tick, then tc=1 on each of the next two cycles. Without the macro the same stimulus gives 9,0,1.
- Collisions: boundary tick with clr_flag=1 on the same cycle -> sticky_ovf=1. reset=1 during a load of 5 -> count=0, tc=0, sticky_ovf=0.
